// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control pipeline: the stage control bundle,
// forwarding select codes and the all-zero bubble.
package mips_pkg;

    // Field order sets the bit positions: RegDst is bit 8 and RegWrite is bit 0.
    typedef struct packed {
        logic       RegDst;
        logic       Branch;
        logic       MemRead;
        logic       MemtoReg;
        logic [1:0] ALUop;
        logic       MemWrite;
        logic       ALUsrc;
        logic       RegWrite;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Load-use / RAW hazard detection and EX operand forwarding selects.
// Forwarding is present only when CTRL_PIPE_FWD_EN is defined; otherwise every RAW conflict stalls.
module hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_ex_memread,
    input  logic             i_ex_regwrite,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic             i_wb_regwrite,
    input  logic             i_branch_taken,
    output logic             o_stall,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b
);

`ifdef CTRL_PIPE_FWD_EN
    logic w_load_use;
    logic w_unused;

    assign w_unused   = i_ex_regwrite;
    assign w_load_use = i_ex_memread && (i_ex_dst != '0) &&
                        ((i_ex_dst == i_id_rs) || (i_ex_dst == i_id_rt));
    assign o_stall    = w_load_use && !i_branch_taken;

    // The MEM result is younger than the WB result, so it wins when both match.
    always_comb begin
        o_fwd_a = FWD_REG;
        o_fwd_b = FWD_REG;
        if (i_ex_rs != '0 && i_mem_regwrite && i_mem_dst == i_ex_rs)
            o_fwd_a = FWD_MEM;
        else if (i_ex_rs != '0 && i_wb_regwrite && i_wb_dst == i_ex_rs)
            o_fwd_a = FWD_WB;
        if (i_ex_rt != '0 && i_mem_regwrite && i_mem_dst == i_ex_rt)
            o_fwd_b = FWD_MEM;
        else if (i_ex_rt != '0 && i_wb_regwrite && i_wb_dst == i_ex_rt)
            o_fwd_b = FWD_WB;
    end
`else
    logic w_rs_conflict;
    logic w_rt_conflict;
    logic w_unused;

    assign w_unused = ^{i_ex_rs, i_ex_rt, i_wb_dst, i_wb_regwrite, i_ex_memread};

    // WB is not checked: the register file writes before it reads.
    assign w_rs_conflict = (i_id_rs != '0) &&
                           ((i_ex_regwrite && i_ex_dst == i_id_rs) ||
                            (i_mem_regwrite && i_mem_dst == i_id_rs));
    assign w_rt_conflict = (i_id_rt != '0) &&
                           ((i_ex_regwrite && i_ex_dst == i_id_rt) ||
                            (i_mem_regwrite && i_mem_dst == i_id_rt));
    assign o_stall = (w_rs_conflict || w_rt_conflict) && !i_branch_taken;
    assign o_fwd_a = FWD_REG;
    assign o_fwd_b = FWD_REG;
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX/MEM/WB control-bundle stage registers with stall bubbles and branch flush.
// Define CTRL_PIPE_FWD_EN to build with operand forwarding (stall on load-use only).
module ctrl_pipeline
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegDst,
    input  logic             Branch,
    input  logic             MemRead,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             ALUsrc,
    input  logic             RegWrite,
    input  logic [1:0]       ALUop,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    output logic             stall,
    output logic [8:0]       ex_ctrl,
    output logic [8:0]       mem_ctrl,
    output logic [8:0]       wb_ctrl,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    ctrl_t             w_id_ctrl;
    logic [REG_W-1:0]  w_id_dst;
    logic              w_stall;

    ctrl_t             r_ex_ctrl;
    ctrl_t             r_mem_ctrl;
    ctrl_t             r_wb_ctrl;
    logic [REG_W-1:0]  r_ex_dst;
    logic [REG_W-1:0]  r_mem_dst;
    logic [REG_W-1:0]  r_wb_dst;
    logic [REG_W-1:0]  r_ex_rs;
    logic [REG_W-1:0]  r_ex_rt;

    assign w_id_ctrl = {RegDst, Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite};
    assign w_id_dst  = RegDst ? id_rd : id_rt;

    // EX->MEM->WB always advance; a taken branch squashes EX and MEM, a stall bubbles EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_mem_ctrl <= CTRL_BUBBLE;
            r_wb_ctrl  <= CTRL_BUBBLE;
            r_ex_dst   <= '0;
            r_mem_dst  <= '0;
            r_wb_dst   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
        end else begin
            r_wb_ctrl <= r_mem_ctrl;
            r_wb_dst  <= r_mem_dst;
            if (branch_taken) begin
                r_mem_ctrl <= CTRL_BUBBLE;
                r_mem_dst  <= '0;
                r_ex_ctrl  <= CTRL_BUBBLE;
                r_ex_dst   <= '0;
                r_ex_rs    <= '0;
                r_ex_rt    <= '0;
            end else begin
                r_mem_ctrl <= r_ex_ctrl;
                r_mem_dst  <= r_ex_dst;
                if (w_stall) begin
                    r_ex_ctrl <= CTRL_BUBBLE;
                    r_ex_dst  <= '0;
                    r_ex_rs   <= '0;
                    r_ex_rt   <= '0;
                end else begin
                    r_ex_ctrl <= w_id_ctrl;
                    r_ex_dst  <= w_id_dst;
                    r_ex_rs   <= id_rs;
                    r_ex_rt   <= id_rt;
                end
            end
        end
    end

    hazard_fwd_unit #(.REG_W(REG_W)) u_hazard (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .i_ex_dst       (r_ex_dst),
        .i_ex_memread   (r_ex_ctrl.MemRead),
        .i_ex_regwrite  (r_ex_ctrl.RegWrite),
        .i_mem_dst      (r_mem_dst),
        .i_mem_regwrite (r_mem_ctrl.RegWrite),
        .i_wb_dst       (r_wb_dst),
        .i_wb_regwrite  (r_wb_ctrl.RegWrite),
        .i_branch_taken (branch_taken),
        .o_stall        (w_stall),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );

    assign stall    = w_stall;
    assign ex_ctrl  = r_ex_ctrl;
    assign mem_ctrl = r_mem_ctrl;
    assign wb_ctrl  = r_wb_ctrl;
    assign ex_dst   = r_ex_dst;
    assign mem_dst  = r_mem_dst;
    assign wb_dst   = r_wb_dst;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed hazard scenarios plus randomized
// instruction streams compared against an instruction-level pipeline model.
module tb_ctrl_pipeline;

    localparam logic [8:0] RTYPE = 9'b100010001;
    localparam logic [8:0] LW    = 9'b001100011;
    localparam logic [8:0] SW    = 9'b000000110;
    localparam logic [8:0] NOP   = 9'b000000000;

    typedef struct packed {
        logic [8:0] ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } instT;

    logic       clk;
    logic       rst_n;
    logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite;
    logic [1:0] ALUop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       branch_taken;
    logic       stall;
    logic [8:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic [1:0] fwd_a, fwd_b;

    int   checkCount = 0;
    int   failCount  = 0;
    instT mEx, mMem, mWb;

    ctrl_pipeline #(.REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite), .ALUop(ALUop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // An instruction produces register r if it writes a nonzero destination equal to r.
    function automatic logic producesReg(instT s, logic [4:0] r);
        return (r != 5'd0) && s.ctrl[0] && (s.dst == r);
    endfunction

    function automatic logic modelStall(logic [4:0] rs, logic [4:0] rt, logic bt);
        if (bt) return 1'b0;
`ifdef CTRL_PIPE_FWD_EN
        return mEx.ctrl[6] && (mEx.dst != 5'd0) && (mEx.dst == rs || mEx.dst == rt);
`else
        return producesReg(mEx, rs) || producesReg(mEx, rt) ||
               producesReg(mMem, rs) || producesReg(mMem, rt);
`endif
    endfunction

    function automatic logic [1:0] modelFwd(logic [4:0] r);
`ifdef CTRL_PIPE_FWD_EN
        if (producesReg(mMem, r)) return 2'b10;
        if (producesReg(mWb, r))  return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 16'(stall), 16'd0);
        checkOutput({tag, "_fwd_a"}, 16'(fwd_a), 16'd0);
        checkOutput({tag, "_fwd_b"}, 16'(fwd_b), 16'd0);
        checkOutput({tag, "_ex_ctrl"}, 16'(ex_ctrl), 16'd0);
        checkOutput({tag, "_mem_ctrl"}, 16'(mem_ctrl), 16'd0);
        checkOutput({tag, "_wb_ctrl"}, 16'(wb_ctrl), 16'd0);
        checkOutput({tag, "_ex_dst"}, 16'(ex_dst), 16'd0);
        checkOutput({tag, "_mem_dst"}, 16'(mem_dst), 16'd0);
        checkOutput({tag, "_wb_dst"}, 16'(wb_dst), 16'd0);
    endtask

    // Drive one ID-stage instruction, check all outputs against the model, then advance the model.
    task automatic applyStimulus(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic bt);
        logic expStall;
        instT incoming;
        @(negedge clk);
        {RegDst, Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite} = c;
        id_rs = rs; id_rt = rt; id_rd = rd; branch_taken = bt;
        #1;
        expStall = modelStall(rs, rt, bt);
        checkOutput("stall", 16'(stall), 16'(expStall));
        checkOutput("fwd_a", 16'(fwd_a), 16'(modelFwd(mEx.rs)));
        checkOutput("fwd_b", 16'(fwd_b), 16'(modelFwd(mEx.rt)));
        checkOutput("ex_ctrl", 16'(ex_ctrl), 16'(mEx.ctrl));
        checkOutput("mem_ctrl", 16'(mem_ctrl), 16'(mMem.ctrl));
        checkOutput("wb_ctrl", 16'(wb_ctrl), 16'(mWb.ctrl));
        checkOutput("ex_dst", 16'(ex_dst), 16'(mEx.dst));
        checkOutput("mem_dst", 16'(mem_dst), 16'(mMem.dst));
        checkOutput("wb_dst", 16'(wb_dst), 16'(mWb.dst));
        incoming = '{ctrl: c, rs: rs, rt: rt, dst: (c[8] ? rd : rt)};
        mWb = mMem;
        if (bt) begin
            mMem = '0;
            mEx  = '0;
        end else begin
            mMem = mEx;
            mEx  = expStall ? instT'('0) : incoming;
        end
    endtask

    // Reset asserted between clock edges: outputs must clear without waiting for a clock.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #2;
        {RegDst, Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite} = 9'd0;
        id_rs = '0; id_rt = '0; id_rd = '0; branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAllZero(tag);
        mEx = '0; mMem = '0; mWb = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [8:0] c;
        logic [4:0] rs, rt, rd;
        logic       bt;

        rst_n = 1'b0;
        {RegDst, Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite} = 9'd0;
        id_rs = '0; id_rt = '0; id_rd = '0; branch_taken = 1'b0;
        mEx = '0; mMem = '0; mWb = '0;
        #2;
        checkAllZero("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

`ifdef CTRL_PIPE_FWD_EN
        $display("[TB] directed scenarios, forwarding build");
        applyStimulus(LW, 5'd0, 5'd8, 5'd0, 1'b0);
        applyStimulus(RTYPE, 5'd8, 5'd1, 5'd2, 1'b0);
        checkOutput("lu_stall_hi", 16'(stall), 16'd1);
        applyStimulus(RTYPE, 5'd8, 5'd1, 5'd2, 1'b0);
        checkOutput("lu_bubble", 16'(ex_ctrl), 16'd0);
        checkOutput("lu_stall_lo", 16'(stall), 16'd0);

        pulseReset("rst_b1");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd9, 1'b0);
        applyStimulus(RTYPE, 5'd9, 5'd0, 5'd4, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("fwd_mem_only", 16'(fwd_a), 16'b10);
        pulseReset("rst_b2");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd9, 1'b0);
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd9, 1'b0);
        applyStimulus(RTYPE, 5'd9, 5'd0, 5'd4, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("fwd_mem_over_wb", 16'(fwd_a), 16'b10);

        pulseReset("rst_c1");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd10, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        applyStimulus(RTYPE, 5'd0, 5'd10, 5'd4, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("fwd_wb", 16'(fwd_b), 16'b01);
        pulseReset("rst_c2");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd4, 1'b0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("fwd_r0", 16'(fwd_b), 16'b00);
`else
        $display("[TB] directed scenarios, stall-only build");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd11, 1'b0);
        applyStimulus(SW, 5'd1, 5'd11, 5'd0, 1'b0);
        checkOutput("raw_stall1", 16'(stall), 16'd1);
        checkOutput("raw_fwd1", 16'({fwd_a, fwd_b}), 16'd0);
        applyStimulus(SW, 5'd1, 5'd11, 5'd0, 1'b0);
        checkOutput("raw_stall2", 16'(stall), 16'd1);
        checkOutput("raw_fwd2", 16'({fwd_a, fwd_b}), 16'd0);
        applyStimulus(SW, 5'd1, 5'd11, 5'd0, 1'b0);
        checkOutput("raw_stall3", 16'(stall), 16'd0);
        checkOutput("raw_fwd3", 16'({fwd_a, fwd_b}), 16'd0);
`endif

        pulseReset("rst_d");
        applyStimulus(RTYPE, 5'd0, 5'd0, 5'd5, 1'b0);
        applyStimulus(LW, 5'd0, 5'd8, 5'd0, 1'b0);
        applyStimulus(RTYPE, 5'd8, 5'd0, 5'd6, 1'b1);
        checkOutput("br_stall_masked", 16'(stall), 16'd0);
        applyStimulus(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("br_ex_flush", 16'(ex_ctrl), 16'd0);
        checkOutput("br_mem_flush", 16'(mem_ctrl), 16'd0);
        checkOutput("br_wb_adv", 16'(wb_ctrl), 16'(RTYPE));
        pulseReset("rst_mid");

        $display("[TB] randomized stream");
        for (int i = 0; i < 3000; i++) begin
            c  = 9'($urandom_range(0, 511));
            rs = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rt = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rd = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            bt = ($urandom % 10 == 0);
            if ($urandom % 300 == 0)
                pulseReset("rst_rand");
            else
                applyStimulus(c, rs, rt, rd, bt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite  input  1 each  decoded control bundle of the ID-stage instruction.
REQ-005 SHALL have port ALUop  input  2  ID-stage ALU operation class.
REQ-006 SHALL have ports id_rs, id_rt, id_rd  input  REG_W each  ID-stage register fields.
REQ-007 SHALL have port branch_taken  input  1  MEM-stage branch resolved taken.
REQ-008 SHALL have port stall  output  1  hold PC and IF/ID this cycle.
REQ-009 SHALL have ports ex_ctrl, mem_ctrl, wb_ctrl  output  9 each  registered control bundles {RegDst,Branch,MemRead,MemtoReg,ALUop,MemWrite,ALUsrc,RegWrite}.
REQ-010 SHALL have ports ex_dst, mem_dst, wb_dst  output  REG_W each  destination register per stage.
REQ-011 SHALL have ports fwd_a, fwd_b  output  2 each  EX operand source select: 00 regfile, 10 MEM, 01 WB.

Function
REQ-012 SHALL advance EX->MEM->WB every cycle unconditionally; only ID->EX entry is gated.
REQ-013 SHALL capture at ID->EX: control bundle, id_rs, id_rt, and dst = RegDst ? id_rd : id_rt.
REQ-014 SHALL assert stall combinationally when EX MemRead=1, ex_dst!=0, and ex_dst equals id_rs or id_rt (load-use).
REQ-015 SHALL, while stall=1, load an all-zero bubble (controls 0, dst 0) into EX; MEM/WB advance normally.
REQ-016 SHALL, when branch_taken=1, zero the bundles entering EX and MEM on that edge (flush two younger instructions); WB advances normally.
REQ-017 SHALL give branch_taken priority over stall; stall output forced 0 in that cycle.
REQ-018 SHALL never treat register 0 as a hazard or forwarding source.
REQ-019 SHALL produce fwd_a/fwd_b combinationally from EX rs/rt: 10 when MEM RegWrite and mem_dst matches; else 01 when WB RegWrite and wb_dst matches; else 00 (MEM beats WB).
REQ-020 SHALL have stall latency zero cycles (same cycle as hazard), one bubble per load-use.
REQ-021 SHALL behave identically for back-to-back hazards: each re-evaluated every cycle.

Reset
REQ-022 SHALL clear all stage bundles, dst and stored rs/rt fields to 0 asynchronously on rst_n=0.
REQ-023 SHALL drive stall=0 and fwd_a=fwd_b=00 during reset.
REQ-024 SHALL resume on first rising clk after rst_n deasserts; reset mid-stream discards all in-flight instructions.

Configuration
REQ-025 SHALL use macro CTRL_PIPE_FWD_EN to compile forwarding in or out.
REQ-026 SHALL, with CTRL_PIPE_FWD_EN defined, implement REQ-014 and REQ-019 as stated.
REQ-027 SHALL, without CTRL_PIPE_FWD_EN, tie fwd_a=fwd_b=00 and assert stall whenever id_rs/id_rt (nonzero) matches ex_dst with EX RegWrite or mem_dst with MEM RegWrite; WB conflicts resolved by write-first register file.

Structure
REQ-028 SHALL place the control-bundle struct/bit-field positions, FWD_REG/FWD_MEM/FWD_WB select codes, and bubble constant in shared package mips_pkg.
REQ-029 SHALL implement hazard/forwarding comparison as one sub-module, hazard_fwd_unit; stage registers stay in ctrl_pipeline.

Verification
REQ-030 SHALL cover: lw (MemRead=1,RegWrite=1,dst=$8) in EX, ID rs=$8 -> stall=1 one cycle, ex_ctrl=0 next cycle, then stall=0.
REQ-031 SHALL cover: R-type dst=$9 in MEM, EX rs=$9 -> fwd_a=10; same dst also in WB -> still 10.
REQ-032 SHALL cover: R-type dst=$10 in WB only, EX rt=$10 -> fwd_b=01; dst=$0 case -> fwd_b=00.
REQ-033 SHALL cover: branch_taken=1 concurrent with load-use -> stall=0, next edge ex_ctrl=0 and mem_ctrl=0, wb_ctrl = prior mem_ctrl.
REQ-034 SHALL cover: rst_n pulled low mid-stream between edges -> all outputs 0 immediately, no clock required.
REQ-035 SHALL cover: build without CTRL_PIPE_FWD_EN, R-type dst=$11 in EX then sw rt=$11 in ID -> stall=1 for two cycles, fwd_a/fwd_b=00 throughout.
